// File: rtl/register_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Default sizes, a constant log2 and a saturating adder.
package register_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int NREAD_D = 2;
    localparam int USE_W_D = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          width
    );
        logic [64:0] s;
        logic [64:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (65'd1 << width) - 65'd1;
        return (s > m) ? m[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/reg_usage_tracker.sv
// Per-register usage counters and most-used register tracking.
// Ties always keep the incumbent; x0 is never counted.
module reg_usage_tracker
    import register_pkg::*;
#(
    parameter  int NREGS = NREGS_D,
    parameter  int USE_W = USE_W_D,
    parameter  int IW    = 2,
    localparam int AW    = clog2(NREGS)
) (
    input  logic               clk,
    input  logic               clear_i,
    input  logic [NREGS*IW-1:0] inc_i,
    output logic [AW-1:0]      most_o,
    output logic [USE_W-1:0]   most_cnt_o
);

    logic [USE_W-1:0] use_q   [NREGS];
    logic [USE_W-1:0] new_use [NREGS];
    logic [AW-1:0]    most_q, most_d;
    logic [USE_W-1:0] mcnt_q, mcnt_d;
    logic [AW-1:0]    ch_idx;
    logic [USE_W-1:0] ch_val;
    logic             ch_hit;

    // Post-update usage counts, saturating; x0 pinned at zero
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (i == 0) begin
                new_use[i] = '0;
            end else begin
                new_use[i] = USE_W'(sat_add(64'(use_q[i]),
                                            64'(inc_i[i*IW +: IW]),
                                            USE_W));
            end
        end
    end

    // Lowest-index touched register with the largest new count challenges the incumbent
    always_comb begin
        ch_idx = '0;
        ch_val = '0;
        ch_hit = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (inc_i[i*IW +: IW] != '0 && (!ch_hit || new_use[i] > ch_val)) begin
                ch_hit = 1'b1;
                ch_idx = AW'(i);
                ch_val = new_use[i];
            end
        end
        most_d = most_q;
        if (ch_hit && ch_val > new_use[most_q]) begin
            most_d = ch_idx;
        end
        mcnt_d = new_use[most_d];
    end

    // Usage state update with synchronous clear
    always_ff @(posedge clk) begin
        if (clear_i) begin
            for (int i = 0; i < NREGS; i++) use_q[i] <= '0;
            most_q <= '0;
            mcnt_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) use_q[i] <= new_use[i];
            most_q <= most_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign most_o     = most_q;
    assign most_cnt_o = mcnt_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write bypass and access statistics.
// Reads are combinational; x0 reads as zero and is never written.
module register_file_mp
    import register_pkg::*;
#(
    parameter  int XLEN   = XLEN_D,
    parameter  int NREGS  = NREGS_D,
    parameter  int NREAD  = NREAD_D,
    parameter  bit BYPASS = 1'b1,
    parameter  int CNT_W  = 32,
    parameter  int USE_W  = USE_W_D,
    localparam int AW     = clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD-1:0]      enRead,
    input  logic [NREAD*AW-1:0]   rsAddr,
    output logic [NREAD*XLEN-1:0] rsData,
    input  logic                  enWrite,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       rdData,
    input  logic                  statClear,
    output logic [CNT_W-1:0]      regAccessCount,
    output logic [CNT_W-1:0]      regWriteCount,
    output logic [AW-1:0]         regMostUsed,
    output logic [USE_W-1:0]      regMostUsedCount,
    output logic                  powerActive
);

    localparam int IW = clog2(NREAD + 2);

    logic [XLEN-1:0]     mem_q [NREGS];
    logic [AW-1:0]       ra    [NREAD];
    logic [NREGS*IW-1:0] inc;
    logic [IW-1:0]       total;
    logic                wr_cnt;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    wrc_q, wrc_d;
    logic                pa_q, pa_d;

    // Split the packed read-address bus into per-port addresses
    always_comb begin
        for (int p = 0; p < NREAD; p++) ra[p] = rsAddr[p*AW +: AW];
    end

    // Read muxes: x0 forced to zero, same-cycle write forwarded when enabled
    always_comb begin
        rsData = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (ra[p] == '0) begin
                rsData[p*XLEN +: XLEN] = '0;
            end else if (BYPASS && enWrite && rd == ra[p]) begin
                rsData[p*XLEN +: XLEN] = rdData;
            end else begin
                rsData[p*XLEN +: XLEN] = mem_q[ra[p]];
            end
        end
    end

    // Per-register increments and cycle total of counted accesses
    always_comb begin
        inc    = '0;
        total  = '0;
        wr_cnt = enWrite && (rd != '0);
        for (int p = 0; p < NREAD; p++) begin
            if (enRead[p] && ra[p] != '0) begin
                inc[ra[p]*IW +: IW] = inc[ra[p]*IW +: IW] + IW'(1);
                total = total + IW'(1);
            end
        end
        if (wr_cnt) begin
            inc[rd*IW +: IW] = inc[rd*IW +: IW] + IW'(1);
            total = total + IW'(1);
        end
    end

    // Saturating total counters and activity flag next state
    always_comb begin
        acc_d = CNT_W'(sat_add(64'(acc_q), 64'(total), CNT_W));
        wrc_d = CNT_W'(sat_add(64'(wrc_q), 64'(wr_cnt), CNT_W));
        pa_d  = (total != '0);
    end

    // Register storage; reset wipes contents, x0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (wr_cnt) begin
            mem_q[rd] <= rdData;
        end
    end

    // Total statistics registers, cleared by reset or statClear
    always_ff @(posedge clk) begin
        if (reset || statClear) begin
            acc_q <= '0;
            wrc_q <= '0;
            pa_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            wrc_q <= wrc_d;
            pa_q  <= pa_d;
        end
    end

    reg_usage_tracker #(
        .NREGS (NREGS),
        .USE_W (USE_W),
        .IW    (IW)
    ) u_usage (
        .clk        (clk),
        .clear_i    (reset || statClear),
        .inc_i      (inc),
        .most_o     (regMostUsed),
        .most_cnt_o (regMostUsedCount)
    );

    assign regAccessCount = acc_q;
    assign regWriteCount  = wrc_q;
    assign powerActive    = pa_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed vector table, saturation
// sequences and randomized traffic against a behavioural model.
module tb_register_file_mp;

    localparam logic [31:0] D    = 32'h0005ADAD;
    localparam longint      UMAX = 65535;
    localparam longint      CMAX = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, statClear, enWrite;
    logic [1:0]  enRead;
    logic [9:0]  rsAddr;
    logic [4:0]  rd;
    logic [31:0] rdData;

    logic [63:0] m_rs, n_rs, s_rs;
    logic [31:0] m_acc, m_wr, n_acc, n_wr, s_acc, s_wr;
    logic [4:0]  m_most, n_most, s_most;
    logic [15:0] m_mcnt, n_mcnt;
    logic [3:0]  s_mcnt;
    logic        m_pa, n_pa, s_pa;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    register_file_mp #(.BYPASS(1'b1)) dut_m (
        .clk(clk), .reset(reset), .enRead(enRead), .rsAddr(rsAddr),
        .rsData(m_rs), .enWrite(enWrite), .rd(rd), .rdData(rdData),
        .statClear(statClear), .regAccessCount(m_acc),
        .regWriteCount(m_wr), .regMostUsed(m_most),
        .regMostUsedCount(m_mcnt), .powerActive(m_pa)
    );

    register_file_mp #(.BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .enRead(enRead), .rsAddr(rsAddr),
        .rsData(n_rs), .enWrite(enWrite), .rd(rd), .rdData(rdData),
        .statClear(statClear), .regAccessCount(n_acc),
        .regWriteCount(n_wr), .regMostUsed(n_most),
        .regMostUsedCount(n_mcnt), .powerActive(n_pa)
    );

    register_file_mp #(.USE_W(4)) dut_s (
        .clk(clk), .reset(reset), .enRead(enRead), .rsAddr(rsAddr),
        .rsData(s_rs), .enWrite(enWrite), .rd(rd), .rdData(rdData),
        .statClear(statClear), .regAccessCount(s_acc),
        .regWriteCount(s_wr), .regMostUsed(s_most),
        .regMostUsedCount(s_mcnt), .powerActive(s_pa)
    );

    // behavioural model of the default-configuration file
    logic [31:0] md_mem [32];
    longint      md_use [32];
    longint      md_acc, md_wr, md_mcnt;
    int          md_most;
    bit          md_pa;

    task automatic md_clear_stats();
        for (int i = 0; i < 32; i++) md_use[i] = 0;
        md_acc = 0; md_wr = 0; md_mcnt = 0; md_most = 0; md_pa = 0;
    endtask

    task automatic model_edge();
        int     cnt [32];
        longint nu  [32];
        int     tot, ch, a;
        bit     wc;
        if (reset) begin
            md_clear_stats();
            for (int i = 0; i < 32; i++) md_mem[i] = 0;
            return;
        end
        wc = enWrite && rd != 0;
        if (statClear) begin
            md_clear_stats();
            if (wc) md_mem[rd] = rdData;
            return;
        end
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        tot = 0;
        for (int p = 0; p < 2; p++) begin
            a = int'(rsAddr[p*5 +: 5]);
            if (enRead[p] && a != 0) begin cnt[a]++; tot++; end
        end
        if (wc) begin cnt[rd]++; tot++; end
        md_acc = (md_acc + tot > CMAX) ? CMAX : md_acc + tot;
        md_wr  = (md_wr + wc > CMAX) ? CMAX : md_wr + wc;
        nu[0] = 0;
        for (int i = 1; i < 32; i++)
            nu[i] = (md_use[i] + cnt[i] > UMAX) ? UMAX : md_use[i] + cnt[i];
        ch = -1;
        for (int i = 1; i < 32; i++)
            if (cnt[i] > 0 && (ch < 0 || nu[i] > nu[ch])) ch = i;
        if (ch >= 0 && nu[ch] > nu[md_most]) md_most = ch;
        for (int i = 0; i < 32; i++) md_use[i] = nu[i];
        md_mcnt = nu[md_most];
        md_pa = tot > 0;
        if (wc) md_mem[rd] = rdData;
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'd0;
        if (byp && enWrite && rd == a) return rdData;
        return md_mem[a];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit sc, input bit [1:0] er,
                         input bit [4:0] a0, input bit [4:0] a1,
                         input bit we, input bit [4:0] wa, input bit [31:0] wd);
        reset = r; statClear = sc; enRead = er;
        rsAddr = {a1, a0}; enWrite = we; rd = wa; rdData = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " acc"}, 64'(m_acc), 64'(md_acc));
        chk({tag, " wr"}, 64'(m_wr), 64'(md_wr));
        chk({tag, " most"}, 64'(m_most), 64'(md_most));
        chk({tag, " mcnt"}, 64'(m_mcnt), 64'(md_mcnt));
        chk({tag, " pa"}, 64'(m_pa), 64'(md_pa));
    endtask

    typedef struct {
        bit        rst, sc;
        bit [1:0]  er;
        bit [4:0]  a0, a1;
        bit        we;
        bit [4:0]  wa;
        bit [31:0] r0, r1, nb0;
        int        acc, wr, most, mcnt;
        bit        pa;
    } vec_t;

    function automatic vec_t mk(bit rst, bit sc, bit [1:0] er, bit [4:0] a0,
                                bit [4:0] a1, bit we, bit [4:0] wa,
                                bit [31:0] r0, bit [31:0] r1, bit [31:0] nb0,
                                int acc, int wr, int most, int mcnt, bit pa);
        vec_t v;
        v.rst = rst; v.sc = sc; v.er = er; v.a0 = a0; v.a1 = a1;
        v.we = we; v.wa = wa; v.r0 = r0; v.r1 = r1; v.nb0 = nb0;
        v.acc = acc; v.wr = wr; v.most = most; v.mcnt = mcnt; v.pa = pa;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // reset twice, then x0 write is ignored
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0, 0,0,0, 0,0,0,0,0));
        // x1 write with same-cycle read, then plain read
        tbl.push_back(mk(0,0,0,1,1,1,1, D,D,0, 1,1,1,1,1));
        tbl.push_back(mk(0,0,0,1,1,0,0, D,D,D, 1,1,1,1,0));
        tbl.push_back(mk(0,1,3,1,1,0,0, D,D,D, 0,0,0,0,0));
        // three writes to x5, then ten dual reads {x1,x5}
        tbl.push_back(mk(0,0,0,5,5,1,5, D,D,0, 1,1,5,1,1));
        tbl.push_back(mk(0,0,0,5,5,1,5, D,D,D, 2,2,5,2,1));
        tbl.push_back(mk(0,0,0,5,5,1,5, D,D,D, 3,3,5,3,1));
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(0,0,3,5,1,0,0, D,D,D, 3+2*k,3,5,3+k,1));
        // tie rule: x3 four times, x7 four times, one more x7
        tbl.push_back(mk(0,1,0,5,0,0,0, D,0,D, 0,0,0,0,0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(0,0,1,3,0,0,0, 0,0,0, k,0,3,k,1));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(0,0,1,7,0,0,0, 0,0,0, 4+k,0,3,4,1));
        tbl.push_back(mk(0,0,1,7,0,0,0, 0,0,0, 9,0,7,5,1));
        // powerActive low on an idle cycle, high after a counted read
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 9,0,7,5,0));
        tbl.push_back(mk(0,0,1,5,0,0,0, D,0,D, 10,0,7,5,1));
        // statClear keeps contents
        tbl.push_back(mk(0,1,1,5,0,0,0, D,0,D, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,5,0,0,0, D,0,D, 0,0,0,0,0));

        apply(1,0,0,0,0,0,0,0);
        @(negedge clk);

        foreach (tbl[k]) begin
            vec_t v;
            string t;
            v = tbl[k];
            t = $sformatf("row%0d", k);
            apply(v.rst, v.sc, v.er, v.a0, v.a1, v.we, v.wa, D);
            #1;
            chk({t, " rs0"}, 64'(m_rs[31:0]), 64'(v.r0));
            chk({t, " rs1"}, 64'(m_rs[63:32]), 64'(v.r1));
            chk({t, " nb_rs0"}, 64'(n_rs[31:0]), 64'(v.nb0));
            tick();
            chk({t, " acc"}, 64'(m_acc), 64'(v.acc));
            chk({t, " wr"}, 64'(m_wr), 64'(v.wr));
            chk({t, " most"}, 64'(m_most), 64'(v.most));
            chk({t, " mcnt"}, 64'(m_mcnt), 64'(v.mcnt));
            chk({t, " pa"}, 64'(m_pa), 64'(v.pa));
        end

        // narrow usage counters saturate at 15 and hold
        for (int k = 1; k <= 20; k++) begin
            apply(0,0,1,2,0,0,0,0);
            tick();
            chk($sformatf("sat%0d s_mcnt", k), 64'(s_mcnt), 64'(k > 15 ? 15 : k));
            chk($sformatf("sat%0d s_acc", k), 64'(s_acc), 64'(k));
            check_model($sformatf("sat%0d", k));
        end
        chk("sat s_most", 64'(s_most), 64'd2);

        // an equal saturated count on x9 must not displace x2
        for (int k = 1; k <= 16; k++) begin
            apply(0,0,1,9,0,0,0,0);
            tick();
        end
        chk("sat tie s_most", 64'(s_most), 64'd2);
        chk("sat tie s_mcnt", 64'(s_mcnt), 64'd15);
        check_model("sat tie");

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            string t;
            t = $sformatf("rnd%0d", k);
            apply($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom);
            #1;
            chk({t, " rs0"}, 64'(m_rs[31:0]), 64'(mread(rsAddr[4:0], 1'b1)));
            chk({t, " rs1"}, 64'(m_rs[63:32]), 64'(mread(rsAddr[9:5], 1'b1)));
            chk({t, " nb_rs0"}, 64'(n_rs[31:0]), 64'(mread(rsAddr[4:0], 1'b0)));
            tick();
            check_model(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the single-configuration two-read/one-write file. It provides NREAD asynchronous read ports, one write port, optional write-to-read bypass, and hard-wired-zero x0. Built-in statistics track total accesses, total writes, per-register usage, the most-used register and a power-activity flag. It sits between decode (read addresses) and writeback (write port); the statistics feed the performance-monitor bus.

## Interface
- XLEN, 32: data width.
- NREGS, 32: register count; power of two, ≥ 2; AW = log2(NREGS).
- NREAD, 2: read ports, 1–4.
- BYPASS, 1: 1 means a same-cycle write is forwarded to matching read ports.
- CNT_W, 32: width of the total counters.
- USE_W, 16: width of each per-register usage counter.
---
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the register contents and all statistics.
- enRead  in  NREAD  per-port read valid; used only by the statistics, data is always driven.
- rsAddr  in  NREAD*AW  read addresses; port p uses bits [p*AW +: AW].
- rsData  out  NREAD*XLEN  read data; port p uses bits [p*XLEN +: XLEN].
- enWrite  in  1  write enable.
- rd  in  AW  write address.
- rdData  in  XLEN  write data.
- statClear  in  1  synchronous clear of statistics only.
- regAccessCount  out  CNT_W  saturating count of counted accesses.
- regWriteCount  out  CNT_W  saturating count of counted writes.
- regMostUsed  out  AW  index of the most-used register.
- regMostUsedCount  out  USE_W  usage count of regMostUsed.
- powerActive  out  1  high when the previous cycle had at least one counted access.

## Operation
- **Write:** on a clock edge with enWrite=1 and rd≠0, mem[rd] ← rdData. A write with rd=0 is discarded and is not counted.
- **Read:** combinational.
  - rsAddr=0 returns 0.
  - With BYPASS=1, enWrite=1 and rd=rsAddr≠0, the port returns rdData.
  - Otherwise the port returns mem[rsAddr].
- **Counted access, per cycle:**
  - each port with enRead[p]=1 and rsAddr≠0 counts once;
  - a write with enWrite=1 and rd≠0 counts once.
- **Total counters:**
  - regAccessCount += the number of counted accesses in the cycle (0..NREAD+1).
  - regWriteCount += 1 per counted write.
  - Both saturate at all-ones.
- **Usage counters:**
  - use[i] += the number of counted accesses targeting register i in the cycle, including several ports on the same register.
  - Saturate at 2^USE_W−1.
  - use[0] stays 0.
- **Most-used tracking:**
  - newUse = the post-update counts.
  - Challenger = the lowest-index register touched this cycle with the maximum newUse.
  - regMostUsed ← challenger only if newUse[challenger] > newUse[regMostUsed]; ties keep the incumbent.
  - regMostUsedCount ← newUse[the resulting regMostUsed].
- **powerActive** ← (counted accesses > 0), registered.
- **statClear:** zeroes all counters, regMostUsed, regMostUsedCount and powerActive. Register contents are kept. Accesses in the clearing cycle are not counted.
- **reset:** same as statClear, plus every mem entry is set to 0. reset has priority over write and statClear.

## Timing
- Read latency is 0 (combinational). A written value is visible from the edge after the write (or in the same cycle via bypass).
- Every statistics output is registered: it reflects accesses up to and including cycle N from the edge that ends cycle N.
- Reset values:
  - rsData = 0 for all addresses;
  - all counters = 0;
  - regMostUsed = 0;
  - regMostUsedCount = 0;
  - powerActive = 0.
- A reset asserted mid-sequence takes effect at the next edge. Reads in that cycle still show the pre-reset contents.
- When saturated, a counter holds its value. With equal saturated usage counts, regMostUsed does not change.

## Structure
- Package register_pkg holds:
  - default parameter constants (XLEN_D, NREGS_D, NREAD_D, USE_W_D);
  - function clog2;
  - function sat_add(a, b, width).
- Sub-module reg_usage_tracker holds the per-register usage counters, the challenger argmax, the incumbent comparison, and regMostUsed/regMostUsedCount.
  - Inputs: per-cycle increment vector, statClear/reset.
- The top level holds the storage array, the read muxes with bypass, the total counters and powerActive.

## Test plan
- **Reset and x0:**
  - Apply reset for 2 cycles → all rsData=0, all statistics 0.
  - Write x0=0x5ADAD → x0 still reads 0, regWriteCount=0.
- **Write/read and bypass:**
  - Write x1=0x5ADAD with rsAddr[0]=1 in the same cycle → BYPASS=1 reads 0x5ADAD in that cycle; BYPASS=0 reads 0 in that cycle.
  - Both configurations read 0x5ADAD on the next cycle.
- **Counting:**
  - 3 writes to x5, then 10 cycles with enRead=2'b11, rsAddr={x1,x5} → regWriteCount=3, regAccessCount=23, regMostUsed=5, regMostUsedCount=13.
- **Tie rule:**
  - 4 reads of x3, then 4 reads of x7 → regMostUsed=3.
  - One further x7 read → regMostUsed=7, regMostUsedCount=5.
- **powerActive:**
  - A cycle with enRead=0 and rsAddr=0, followed by an x5 read → powerActive=0, then 1 after the next edge.
- **statClear and saturation:**
  - Assert statClear → counters=0, x5 still 0x5ADAD.
  - USE_W=4 with 20 reads of x2 → regMostUsedCount=15, held.
